// File: rtl/apb_regfile_slave.sv
// apb_regfile_slave: APB completer over a bank of 32-bit registers.
// Fixed wait states; response outputs are registered.
module apb_regfile_slave #(
  parameter int NUM_REGS    = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        psel_i,
  input  logic        penable_i,
  input  logic        pwrite_i,
  input  logic [31:0] paddr_i,
  input  logic [31:0] pwdata_i,
  output logic [31:0] prdata_o,
  output logic        pready_o,
  output logic        pslverr_o
);

  localparam int IW = $clog2(NUM_REGS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t        state;
  logic [3:0]    cnt;
  logic          wr_q;
  logic          err_q;
  logic [IW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic [31:0]   regs [NUM_REGS];

  logic [IW-1:0] idx_in;
  logic          err_in;
  logic [31:0]   rd_in;
  logic [31:0]   rd_q;

  // Address decode and read mux for both the live and captured request
  always_comb begin
    idx_in = paddr_i[IW+1:2];
    err_in = (paddr_i[1:0] != 2'b00)
           || (|paddr_i[31:IW+2]);
    rd_in  = (pwrite_i || err_in) ? '0 : regs[idx_in];
    rd_q   = (wr_q || err_q) ? '0 : regs[idx_q];
  end

  // Transfer FSM, register bank and registered response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      prdata_o  <= '0;
      pready_o  <= 1'b0;
      pslverr_o <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
    end else begin
      pready_o  <= 1'b0;
      pslverr_o <= 1'b0;
      prdata_o  <= '0;
      unique case (state)
        S_IDLE: begin
          if (psel_i && !penable_i) begin
            wr_q    <= pwrite_i;
            idx_q   <= idx_in;
            err_q   <= err_in;
            wdata_q <= pwdata_i;
            cnt     <= 4'(WAIT_CYCLES);
            if (WAIT_CYCLES == 0) begin
              state     <= S_DONE;
              pready_o  <= 1'b1;
              pslverr_o <= err_in;
              prdata_o  <= rd_in;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (!psel_i) begin
            state <= S_IDLE;
          end else if (cnt == 4'd1) begin
            state     <= S_DONE;
            pready_o  <= 1'b1;
            pslverr_o <= err_q;
            prdata_o  <= rd_q;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_DONE: begin
          if (psel_i && penable_i && wr_q && !err_q)
            regs[idx_q] <= wdata_q;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
